// File: rtl/ped_xing_ctrl.sv
// ped_xing_ctrl: pedestrian crossing sequencer (WALK -> CAUTION -> HAND) with a tick-driven phase timer.
// Optional build macro CAUTION_FLASH_EN makes the CAUTION lamp flash every FLASH_PERIOD ticks.
module ped_xing_ctrl #(
   parameter int CNT_W          = 8,
   parameter int WALK_TICKS     = 20,
   parameter int CAUTION_TICKS  = 6,
   parameter int HAND_MIN_TICKS = 10,
   parameter int FLASH_PERIOD   = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick,
   input  logic             request,
   input  logic             hold,
   output logic             green_walk,
   output logic             orange_walk,
   output logic             red_hand,
   output logic [1:0]       multiplier,
   output logic             tr,
   output logic             req_pending,
   output logic [CNT_W-1:0] remaining
);

   typedef enum logic [1:0] {
      ST_CAUTION = 2'b00,
      ST_WALK    = 2'b01,
      ST_HAND    = 2'b11
   } state_t;

   localparam logic [CNT_W-1:0] WALK_LD = CNT_W'(WALK_TICKS - 1);
   localparam logic [CNT_W-1:0] CAUT_LD = CNT_W'(CAUTION_TICKS - 1);
   localparam logic [CNT_W-1:0] HAND_LD = CNT_W'(HAND_MIN_TICKS - 1);
   localparam logic [CNT_W-1:0] CNT_0   = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_1   = CNT_W'(1);

   if (CNT_W < 1 || FLASH_PERIOD < 1 ||
       WALK_TICKS < 1 || WALK_TICKS > (2 ** CNT_W) ||
       CAUTION_TICKS < 1 || CAUTION_TICKS > (2 ** CNT_W) ||
       HAND_MIN_TICKS < 1 || HAND_MIN_TICKS > (2 ** CNT_W)) begin : g_bad_param
      $error("ped_xing_ctrl: parameter out of range");
   end

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [CNT_W-1:0] w_cnt_dec;
   logic             r_pend;
   logic             w_pend_nxt;
   logic             w_expire;
   logic             w_new_phase;
   logic             w_orange_lit;
   logic             r_green;
   logic             r_orange;
   logic             r_red;
   logic             r_tr;
   logic [1:0]       r_mult;

   assign w_expire  = (r_cnt == CNT_0) && tick;
   assign w_cnt_dec = (tick && (r_cnt != CNT_0)) ? (r_cnt - CNT_1) : r_cnt;

   // Next-state, phase counter and request latch
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = w_cnt_dec;
      w_pend_nxt  = r_pend;
      case (r_state)
         ST_WALK: begin
            // hold ends WALK at once; it shares the single move into CAUTION with expiry
            if (hold || w_expire) begin
               w_state_nxt = ST_CAUTION;
               w_cnt_nxt   = CAUT_LD;
            end else begin
               w_state_nxt = ST_WALK;
            end
         end
         ST_CAUTION: begin
            if (w_expire) begin
               w_state_nxt = ST_HAND;
               w_cnt_nxt   = HAND_LD;
            end else begin
               w_state_nxt = ST_CAUTION;
            end
         end
         ST_HAND: begin
            if ((r_cnt == CNT_0) && r_pend && !hold) begin
               w_state_nxt = ST_WALK;
               w_cnt_nxt   = WALK_LD;
            end else begin
               w_state_nxt = ST_HAND;
            end
         end
         default: begin
            w_state_nxt = ST_HAND;
            w_cnt_nxt   = HAND_LD;
         end
      endcase
      w_new_phase = (w_state_nxt != r_state);
      if (w_new_phase && (w_state_nxt == ST_WALK)) begin
         w_pend_nxt = 1'b0;
      end else if ((r_state != ST_WALK) && request) begin
         w_pend_nxt = 1'b1;
      end else begin
         w_pend_nxt = r_pend;
      end
   end

`ifdef CAUTION_FLASH_EN
   localparam int FL_W = (FLASH_PERIOD > 1) ? $clog2(FLASH_PERIOD) : 1;
   localparam logic [FL_W-1:0] FL_LD = FL_W'(FLASH_PERIOD - 1);

   logic [FL_W-1:0] r_flash_cnt;
   logic [FL_W-1:0] w_flash_cnt_nxt;
   logic            r_flash_on;
   logic            w_flash_on_nxt;

   // Flash timing: lit on CAUTION entry, toggles after every FLASH_PERIOD ticks
   always_comb begin
      w_flash_cnt_nxt = r_flash_cnt;
      w_flash_on_nxt  = r_flash_on;
      if (w_new_phase) begin
         w_flash_cnt_nxt = FL_LD;
         w_flash_on_nxt  = 1'b1;
      end else if ((r_state == ST_CAUTION) && tick) begin
         if (r_flash_cnt == FL_W'(0)) begin
            w_flash_cnt_nxt = FL_LD;
            w_flash_on_nxt  = !r_flash_on;
         end else begin
            w_flash_cnt_nxt = r_flash_cnt - FL_W'(1);
            w_flash_on_nxt  = r_flash_on;
         end
      end else begin
         w_flash_cnt_nxt = r_flash_cnt;
         w_flash_on_nxt  = r_flash_on;
      end
   end

   // Flash counter registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_flash_cnt <= FL_LD;
         r_flash_on  <= 1'b1;
      end else begin
         r_flash_cnt <= w_flash_cnt_nxt;
         r_flash_on  <= w_flash_on_nxt;
      end
   end

   assign w_orange_lit = w_flash_on_nxt;
`else
   assign w_orange_lit = 1'b1;
`endif

   // State, counter and registered lamp/phase outputs, all updated on the same edge
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state  <= ST_HAND;
         r_cnt    <= HAND_LD;
         r_pend   <= 1'b0;
         r_green  <= 1'b0;
         r_orange <= 1'b0;
         r_red    <= 1'b1;
         r_mult   <= 2'b11;
         r_tr     <= 1'b1;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_pend   <= w_pend_nxt;
         r_green  <= (w_state_nxt == ST_WALK);
         r_orange <= (w_state_nxt == ST_CAUTION) && w_orange_lit;
         r_red    <= (w_state_nxt == ST_HAND);
         r_mult   <= w_state_nxt;
         r_tr     <= w_new_phase;
      end
   end

   assign green_walk  = r_green;
   assign orange_walk = r_orange;
   assign red_hand    = r_red;
   assign multiplier  = r_mult;
   assign tr          = r_tr;
   assign req_pending = r_pend;
   assign remaining   = r_cnt;

endmodule

// File: tb/tb_ped_xing_ctrl.sv
// Self-checking bench for ped_xing_ctrl: phase/elapsed-tick reference model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_ped_xing_ctrl;

   localparam int CW = 8;
   localparam int WT = 4;
`ifdef CAUTION_FLASH_EN
   localparam int CT = 4;
`else
   localparam int CT = 2;
`endif
   localparam int HT = 3;
   localparam int FP = 1;

   localparam int P_HAND = 0;
   localparam int P_WALK = 1;
   localparam int P_CAUT = 2;

   logic          clk;
   logic          reset;
   logic          tick;
   logic          request;
   logic          hold;
   logic          green_walk;
   logic          orange_walk;
   logic          red_hand;
   logic [1:0]    multiplier;
   logic          tr;
   logic          req_pending;
   logic [CW-1:0] remaining;

   int n_checks = 0;
   int n_fail   = 0;

   ped_xing_ctrl #(
      .CNT_W(CW), .WALK_TICKS(WT), .CAUTION_TICKS(CT),
      .HAND_MIN_TICKS(HT), .FLASH_PERIOD(FP)
   ) dut (
      .clk(clk), .reset(reset), .tick(tick), .request(request), .hold(hold),
      .green_walk(green_walk), .orange_walk(orange_walk), .red_hand(red_hand),
      .multiplier(multiplier), .tr(tr), .req_pending(req_pending), .remaining(remaining)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0d expected=%0d at t=%0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model: phase + ticks elapsed in phase ----------------
   function automatic int plen(input int ph);
      case (ph)
         P_WALK:  return WT;
         P_CAUT:  return CT;
         default: return HT;
      endcase
   endfunction

   int m_ph = P_HAND, m_el = 0, m_ft = 0;
   bit m_pend = 0, m_tr = 1, m_valid = 0;
   int n_ph, n_el, n_ft, c_rem;
   bit n_pend, n_tr;

   always_comb begin
      c_rem  = plen(m_ph) - 1 - m_el;
      if (c_rem < 0) c_rem = 0;
      n_ph   = m_ph;
      n_el   = m_el;
      n_ft   = m_ft;
      n_pend = m_pend;
      n_tr   = 1'b0;
      if (!reset) begin
         n_ph = P_HAND; n_el = 0; n_ft = 0; n_pend = 1'b0; n_tr = 1'b1;
      end else begin
         case (m_ph)
            P_WALK:  if (hold || (c_rem == 0 && tick)) n_ph = P_CAUT;
            P_CAUT:  if (c_rem == 0 && tick) n_ph = P_HAND;
            default: if (c_rem == 0 && m_pend && !hold) n_ph = P_WALK;
         endcase
         if (n_ph == P_WALK && m_ph != P_WALK) n_pend = 1'b0;
         else if (m_ph != P_WALK && request) n_pend = 1'b1;
         n_tr = (n_ph != m_ph);
         if (n_tr) begin
            n_el = 0; n_ft = 0;
         end else if (tick) begin
            if (c_rem > 0) n_el = m_el + 1;
            n_ft = m_ft + 1;
         end
      end
   end

   always @(posedge clk) begin
      m_ph   <= n_ph;
      m_el   <= n_el;
      m_ft   <= n_ft;
      m_pend <= n_pend;
      m_tr   <= n_tr;
      if (!reset) m_valid <= 1'b1;
   end

   // every-cycle comparison of all outputs against the model
   always @(negedge clk) begin
      int e_rem;
      bit e_lit;
      logic [1:0] e_mult;
      if (m_valid) begin
         e_rem = plen(m_ph) - 1 - m_el;
         if (e_rem < 0) e_rem = 0;
`ifdef CAUTION_FLASH_EN
         e_lit = (((m_ft / FP) % 2) == 0);
`else
         e_lit = 1'b1;
`endif
         e_mult = (m_ph == P_WALK) ? 2'b01 : (m_ph == P_CAUT) ? 2'b00 : 2'b11;
         chk("model_green",  green_walk,  (m_ph == P_WALK));
         chk("model_orange", orange_walk, (m_ph == P_CAUT) && e_lit);
         chk("model_red",    red_hand,    (m_ph == P_HAND));
         chk("model_mult",   multiplier,  e_mult);
         chk("model_tr",     tr,          m_tr);
         chk("model_pend",   req_pending, m_pend);
         chk("model_rem",    remaining,   e_rem);
      end
   end

   task automatic go(input int n);
      repeat (n) @(negedge clk);
   endtask

   // ---------------- directed stimulus with literal expectations ----------------
   initial begin
      reset = 1'b0; tick = 1'b1; request = 1'b0; hold = 1'b0;
      go(2);
      chk("rst_red", red_hand, 1); chk("rst_mult", multiplier, 3); chk("rst_tr", tr, 1);
      chk("rst_rem", remaining, 2); chk("rst_pend", req_pending, 0); chk("rst_green", green_walk, 0);

      // request served after HAND minimum
      reset = 1'b1; request = 1'b1; go(1); request = 1'b0;
      chk("req_latch", req_pending, 1); chk("req_rem", remaining, 1); chk("req_tr", tr, 0);
      go(2);
      chk("walk_green", green_walk, 1); chk("walk_mult", multiplier, 1);
      chk("walk_tr", tr, 1); chk("walk_pend", req_pending, 0); chk("walk_rem", remaining, 3);
      go(4);
      chk("caut_mult", multiplier, 0); chk("caut_orange", orange_walk, 1); chk("caut_rem", remaining, CT - 1);
`ifdef CAUTION_FLASH_EN
      go(1); chk("flash_1", orange_walk, 0);
      go(1); chk("flash_2", orange_walk, 1);
      go(1); chk("flash_3", orange_walk, 0);
      go(1);
`else
      go(CT);
`endif
      chk("hand_mult", multiplier, 3); chk("hand_tr", tr, 1); chk("hand_rem", remaining, 2);

      // no request: HAND persists
      go(20);
      chk("idle_red", red_hand, 1); chk("idle_rem", remaining, 0); chk("idle_tr", tr, 0);

      // hold terminates WALK; hold ignored in CAUTION; hold inhibits WALK entry
      request = 1'b1; go(1); request = 1'b0;
      chk("h_pend", req_pending, 1);
      go(1); chk("h_walk", green_walk, 1);
      go(1); chk("h_walk_rem", remaining, 2);
      hold = 1'b1; go(1);
      chk("h_caut_mult", multiplier, 0); chk("h_caut_rem", remaining, CT - 1);
      go(CT);
      chk("h_caut_full", red_hand, 1); chk("h_hand_rem", remaining, 2);
      request = 1'b1; go(1); request = 1'b0;
      go(5);
      chk("h_inhibit_red", red_hand, 1); chk("h_inhibit_pend", req_pending, 1);
      hold = 1'b0; go(1);
      chk("h_release_walk", green_walk, 1); chk("h_release_tr", tr, 1);

      // tick stalled mid-WALK; request in WALK ignored
      go(1); chk("stall_pre", remaining, 2);
      tick = 1'b0; request = 1'b1; go(10);
      chk("stall_rem", remaining, 2); chk("stall_green", green_walk, 1); chk("stall_pend", req_pending, 0);
      request = 1'b0; tick = 1'b1;

      // simultaneous hold and expiry
      go(2); chk("sim_rem0", remaining, 0);
      hold = 1'b1; go(1); hold = 1'b0;
      chk("sim_mult", multiplier, 0); chk("sim_rem", remaining, CT - 1); chk("sim_tr", tr, 1);
      go(CT); chk("sim_hand", red_hand, 1);

      // HAND -> WALK with no tick once the minimum has elapsed
      go(2); tick = 1'b0; request = 1'b1; go(1); request = 1'b0;
      go(1); chk("notick_walk", green_walk, 1); chk("notick_rem", remaining, 3);
      tick = 1'b1;

      // reset mid-WALK
      go(1); reset = 1'b0; go(1);
      chk("mrst_red", red_hand, 1); chk("mrst_green", green_walk, 0); chk("mrst_rem", remaining, 2);
      chk("mrst_tr", tr, 1); chk("mrst_pend", req_pending, 0);
      reset = 1'b1;

      // mixed stimulus, checked by the model
      for (int i = 0; i < 400; i++) begin
         tick    = ($urandom_range(0, 3) != 0);
         request = ($urandom_range(0, 5) == 0);
         hold    = ($urandom_range(0, 9) == 0);
         reset   = ($urandom_range(0, 96) != 0);
         go(1);
      end
      reset = 1'b1; tick = 1'b1; request = 1'b0; hold = 1'b0;
      go(2);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
